// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MULDIV = 2'd1,
    HALT   = 2'd2
  } pipe_state_e;

  // Register index that never carries a load-use dependency
  localparam int unsigned REG_ZERO = '0;

  // Width of the multi-cycle stall counter
  localparam int unsigned CNT_W = 4;

  // Stage controls routed by the top to the PC and pipeline registers
  typedef struct packed {
    logic pc_en;
    logic pc_sel_branch;
    logic s1_en;
    logic s2_en;
    logic s1_flush;
    logic s2_flush;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use hazard comparator between st1 and st2
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              s1_valid_i,
  input  logic [ADDR_W-1:0] s1_rs1_i,
  input  logic [ADDR_W-1:0] s1_rs2_i,
  input  logic              s1_uses_rs1_i,
  input  logic              s1_uses_rs2_i,
  input  logic              s2_valid_i,
  input  logic              s2_is_load_i,
  input  logic [ADDR_W-1:0] s2_rd_i,
  output logic              hazard_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = s1_uses_rs1_i && (s1_rs1_i == s2_rd_i);
  assign rs2_match = s1_uses_rs2_i && (s1_rs2_i == s2_rd_i);

  // A load writing r0 produces nothing a consumer could wait for
  assign hazard_o = s2_valid_i && s2_is_load_i && s1_valid_i &&
                    (s2_rd_i != ZERO_ADDR) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 3-stage pipeline sequencing controller; PIPE_PERF_CNT_EN adds the stall_cycles counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int REG_ADDR_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s1_valid,
  input  logic [REG_ADDR_W-1:0] s1_rs1,
  input  logic [REG_ADDR_W-1:0] s1_rs2,
  input  logic                  s1_uses_rs1,
  input  logic                  s1_uses_rs2,
  input  logic                  s2_valid,
  input  logic                  s2_is_load,
  input  logic                  s2_is_muldiv,
  input  logic [REG_ADDR_W-1:0] s2_rd,
  input  logic                  s3_branch_taken,
  input  logic                  halt_req,
  output logic                  pc_en,
  output logic                  pc_sel_branch,
  output logic                  s1_en,
  output logic                  s2_en,
  output logic                  s1_flush,
  output logic                  s2_flush,
  output logic                  muldiv_start,
  output logic                  stall,
  output logic                  halted,
  output logic [15:0]           stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             muldiv_done_q, muldiv_done_d;

  pipe_ctl_t ctl_c;
  logic      muldiv_start_c;
  logic      stall_c;
  logic      halted_c;
  logic      hazard_c;
  logic      muldiv_req_c;

  pipe_hazard_detect #(
    .ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .s1_valid_i    (s1_valid),
    .s1_rs1_i      (s1_rs1),
    .s1_rs2_i      (s1_rs2),
    .s1_uses_rs1_i (s1_uses_rs1),
    .s1_uses_rs2_i (s1_uses_rs2),
    .s2_valid_i    (s2_valid),
    .s2_is_load_i  (s2_is_load),
    .s2_rd_i       (s2_rd),
    .hazard_o      (hazard_c)
  );

  // The op that just finished its stall must not restart when it is seen again in st2
  assign muldiv_req_c = s2_valid && s2_is_muldiv && !muldiv_done_q;

  // Decode stage controls and next state from current state and stage inputs
  always_comb begin
    ctl_c          = '0;
    muldiv_start_c = 1'b0;
    stall_c        = 1'b0;
    halted_c       = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    muldiv_done_d  = muldiv_done_q;

    if (!rst) begin
      ctl_c.s1_flush = 1'b1;
      ctl_c.s2_flush = 1'b1;
      state_d        = RUN;
      cnt_d          = '0;
      muldiv_done_d  = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt_req) begin
            state_d = HALT;
          end else if (s3_branch_taken) begin
            ctl_c.pc_en         = 1'b1;
            ctl_c.pc_sel_branch = 1'b1;
            ctl_c.s1_en         = 1'b1;
            ctl_c.s2_en         = 1'b1;
            ctl_c.s1_flush      = 1'b1;
            ctl_c.s2_flush      = 1'b1;
          end else if (muldiv_req_c) begin
            // st2 holds the op while a bubble drains into st3
            ctl_c.s2_en    = 1'b1;
            ctl_c.s2_flush = 1'b1;
            muldiv_start_c = 1'b1;
            stall_c        = 1'b1;
            cnt_d          = CNT_LOAD;
            state_d        = MULDIV;
          end else if (hazard_c) begin
            // Hold the consumer in st1 and feed a bubble into st2 for one cycle
            ctl_c.s1_en    = 1'b1;
            ctl_c.s1_flush = 1'b1;
            ctl_c.s2_en    = 1'b1;
            stall_c        = 1'b1;
          end else begin
            ctl_c.pc_en = 1'b1;
            ctl_c.s1_en = 1'b1;
            ctl_c.s2_en = 1'b1;
          end
          // st2 receives new contents, so the finished op is gone
          if (ctl_c.s1_en) begin
            muldiv_done_d = 1'b0;
          end
        end
        MULDIV: begin
          ctl_c.s2_en    = 1'b1;
          ctl_c.s2_flush = 1'b1;
          stall_c        = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            cnt_d         = '0;
            muldiv_done_d = 1'b1;
            state_d       = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        HALT: begin
          halted_c = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State, stall counter and muldiv completion flag
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    cnt_q         <= cnt_d;
    muldiv_done_q <= muldiv_done_d;
  end

  assign pc_en         = ctl_c.pc_en;
  assign pc_sel_branch = ctl_c.pc_sel_branch;
  assign s1_en         = ctl_c.s1_en;
  assign s2_en         = ctl_c.s2_en;
  assign s1_flush      = ctl_c.s1_flush;
  assign s2_flush      = ctl_c.s2_flush;
  assign muldiv_start  = muldiv_start_c;
  assign stall         = stall_c;
  assign halted        = halted_c;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = !rst ? 16'h0000 :
                       (stall_c && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'h0001 :
                       stall_cnt_q;

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        s1_valid;
  logic [3:0]  s1_rs1;
  logic [3:0]  s1_rs2;
  logic        s1_uses_rs1;
  logic        s1_uses_rs2;
  logic        s2_valid;
  logic        s2_is_load;
  logic        s2_is_muldiv;
  logic [3:0]  s2_rd;
  logic        s3_branch_taken;
  logic        halt_req;
  logic        pc_en;
  logic        pc_sel_branch;
  logic        s1_en;
  logic        s2_en;
  logic        s1_flush;
  logic        s2_flush;
  logic        muldiv_start;
  logic        stall;
  logic        halted;
  logic [15:0] stall_cycles;

  pipe_ctrl #(
    .MULDIV_CYCLES(4),
    .REG_ADDR_W(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s1_valid        (s1_valid),
    .s1_rs1          (s1_rs1),
    .s1_rs2          (s1_rs2),
    .s1_uses_rs1     (s1_uses_rs1),
    .s1_uses_rs2     (s1_uses_rs2),
    .s2_valid        (s2_valid),
    .s2_is_load      (s2_is_load),
    .s2_is_muldiv    (s2_is_muldiv),
    .s2_rd           (s2_rd),
    .s3_branch_taken (s3_branch_taken),
    .halt_req        (halt_req),
    .pc_en           (pc_en),
    .pc_sel_branch   (pc_sel_branch),
    .s1_en           (s1_en),
    .s2_en           (s2_en),
    .s1_flush        (s1_flush),
    .s2_flush        (s2_flush),
    .muldiv_start    (muldiv_start),
    .stall           (stall),
    .halted          (halted),
    .stall_cycles    (stall_cycles)
  );

  // {pc_en, pc_sel_branch, s1_en, s2_en, s1_flush, s2_flush, muldiv_start, stall, halted}
  localparam logic [8:0] E_RESET  = 9'b0_0_0_0_1_1_0_0_0;
  localparam logic [8:0] E_NORM   = 9'b1_0_1_1_0_0_0_0_0;
  localparam logic [8:0] E_LU     = 9'b0_0_1_1_1_0_0_1_0;
  localparam logic [8:0] E_BR     = 9'b1_1_1_1_1_1_0_0_0;
  localparam logic [8:0] E_MSTART = 9'b0_0_0_1_0_1_1_1_0;
  localparam logic [8:0] E_MWAIT  = 9'b0_0_0_1_0_1_0_1_0;
  localparam logic [8:0] E_HREQ   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_HALTED = 9'b0_0_0_0_0_0_0_0_1;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic [15:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   model_scnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so each cycle's expectation is checked mid-cycle
  initial begin
    exp_t        e;
    logic [8:0]  act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, pc_sel_branch, s1_en, s2_en, s1_flush, s2_flush, muldiv_start, stall, halted};
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL %s ctl: actual=%b required=%b", e.name, act, e.ctl);
        end
        checks++;
        if (stall_cycles !== e.scnt) begin
          failures++;
          $display("FAIL %s stall_cycles: actual=%0d required=%0d", e.name, stall_cycles, e.scnt);
        end
      end
    end
  end

  // Watchdog bounds the whole run
  initial begin
    repeat (2000) @(posedge clk);
    failures++;
    $display("FAIL timeout: actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic idle();
    s1_valid = 0; s1_rs1 = 0; s1_rs2 = 0; s1_uses_rs1 = 0; s1_uses_rs2 = 0;
    s2_valid = 0; s2_is_load = 0; s2_is_muldiv = 0; s2_rd = 0;
    s3_branch_taken = 0; halt_req = 0;
  endtask

  task automatic set_s1(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                        input logic u1, input logic u2);
    s1_valid = v; s1_rs1 = r1; s1_rs2 = r2; s1_uses_rs1 = u1; s1_uses_rs2 = u2;
  endtask

  task automatic set_s2(input logic v, input logic ld, input logic md, input logic [3:0] rd);
    s2_valid = v; s2_is_load = ld; s2_is_muldiv = md; s2_rd = rd;
  endtask

  // Record the expectation for the currently driven inputs, then advance one cycle
  task automatic cyc(input string name, input logic [8:0] ctl);
    exp_t e;
    e.name = name;
    e.ctl  = ctl;
`ifdef PIPE_PERF_CNT_EN
    e.scnt = 16'(model_scnt);
`else
    e.scnt = 16'h0000;
`endif
    exp_q.push_back(e);
    if (!rst) model_scnt = 0;
    else if (ctl[1]) model_scnt++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    model_scnt = 0;
    rst        = 1'b0;
    idle();
    @(posedge clk);
    #2;

    cyc("reset0", E_RESET);
    cyc("reset1", E_RESET);
    rst = 1'b1;
    cyc("idle", E_NORM);

    // Load r3 in st2, st1 reads r3 through rs2
    set_s2(1, 1, 0, 4'd3); set_s1(1, 4'd1, 4'd3, 1, 1);
    cyc("lu_rs2", E_LU);
    set_s2(0, 0, 0, 4'd0);
    cyc("lu_rs2_after", E_NORM);

    // Dependency through rs1, then same register but unused
    set_s2(1, 1, 0, 4'd5); set_s1(1, 4'd5, 4'd2, 1, 0);
    cyc("lu_rs1", E_LU);
    set_s1(1, 4'd5, 4'd2, 0, 1);
    cyc("lu_unused_src", E_NORM);
    set_s1(0, 4'd5, 4'd5, 1, 1);
    cyc("lu_s1_invalid", E_NORM);

    // Load into r0 never stalls
    set_s2(1, 1, 0, 4'd0); set_s1(1, 4'd0, 4'd0, 1, 1);
    cyc("r0_a", E_NORM);
    cyc("r0_b", E_NORM);

    // Branch beats a coincident load-use hazard
    set_s2(1, 1, 0, 4'd3); set_s1(1, 4'd3, 4'd3, 1, 1); s3_branch_taken = 1;
    cyc("br_vs_lu", E_BR);
    idle();
    cyc("br_after", E_NORM);

    // Multi-cycle op: 4 stall cycles, branch/halt ignored while waiting
    set_s2(1, 0, 1, 4'd7);
    cyc("md_start", E_MSTART);
    cyc("md_wait1", E_MWAIT);
    s3_branch_taken = 1;
    cyc("md_wait2_br", E_MWAIT);
    s3_branch_taken = 0; halt_req = 1;
    cyc("md_wait3_halt", E_MWAIT);
    halt_req = 0;
    cyc("md_done_adv", E_NORM);
    set_s2(1, 0, 0, 4'd7);
    cyc("md_next", E_NORM);

    // Branch beats a multi-cycle start
    set_s2(1, 0, 1, 4'd2); s3_branch_taken = 1;
    cyc("br_vs_md", E_BR);
    idle();
    cyc("br_vs_md_after", E_NORM);

    // Reset in the middle of a multi-cycle sequence
    set_s2(1, 0, 1, 4'd4);
    cyc("md2_start", E_MSTART);
    cyc("md2_wait1", E_MWAIT);
    rst = 1'b0;
    cyc("md2_reset", E_RESET);
    rst = 1'b1; idle();
    cyc("md2_post_a", E_NORM);
    cyc("md2_post_b", E_NORM);

    // A fresh load-use stall after reset
    set_s2(1, 1, 0, 4'd9); set_s1(1, 4'd9, 4'd1, 1, 0);
    cyc("lu_post_rst", E_LU);
    idle();

    // Halt is absorbing regardless of inputs
    halt_req = 1;
    cyc("halt_req", E_HREQ);
    halt_req = 0;
    for (int i = 0; i < 10; i++) begin
      s3_branch_taken = i[0];
      set_s2(1, i[2], i[1], 4'd3);
      set_s1(1, 4'd3, 4'd3, 1, 1);
      cyc($sformatf("halted_%0d", i), E_HALTED);
    end
    idle();
    rst = 1'b0;
    cyc("halt_reset", E_RESET);
    rst = 1'b1;
    cyc("halt_exit", E_NORM);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencing controller for the 3-stage CPU pipeline (st1 fetch/decode/regread, st2 execute, st3 memory/writeback). It generates the PC enable, the pipeline register enables, and the flush/bubble controls. It resolves load-use hazards, multi-cycle ALU (mul/div) stalls, taken-branch flushes and halt. Instantiated once inside top, next to the stage modules.

Parameters:
MULDIV_CYCLES, 4, total stall cycles of a multi-cycle ALU op (legal range 2..15)
REG_ADDR_W, 4, register-file address width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
s1_valid  in  1  stage-1 holds a real instruction
s1_rs1  in  REG_ADDR_W  stage-1 source register 1
s1_rs2  in  REG_ADDR_W  stage-1 source register 2
s1_uses_rs1  in  1  stage-1 instruction reads rs1
s1_uses_rs2  in  1  stage-1 instruction reads rs2
s2_valid  in  1  stage-2 holds a real instruction
s2_is_load  in  1  stage-2 instruction is a load
s2_is_muldiv  in  1  stage-2 instruction is a multi-cycle ALU op
s2_rd  in  REG_ADDR_W  stage-2 destination register
s3_branch_taken  in  1  stage-3 resolved a taken branch/jump
halt_req  in  1  halt instruction reached stage 3
pc_en  out  1  PC register load enable
pc_sel_branch  out  1  PC loads branch target instead of PC+1
s1_en  out  1  st1->st2 pipeline register enable
s2_en  out  1  st2->st3 pipeline register enable
s1_flush  out  1  st1->st2 register loads NOP
s2_flush  out  1  st2->st3 register loads NOP
muldiv_start  out  1  one-cycle start pulse to the multi-cycle ALU
stall  out  1  any stall is active this cycle
halted  out  1  pipeline frozen by halt
stall_cycles  out  16  stall-cycle count (see Optional Feature)

Behaviour:
- State and counter are registered; all outputs decode combinationally from current state plus current inputs, taking effect at the next rising edge.
- States: RUN, MULDIV, HALT. Counter cnt is 4 bits.
- While rst=0 at the edge: state<=RUN, cnt<=0. Outputs while rst=0: pc_en=0, pc_sel_branch=0, s1_en=0, s2_en=0, s1_flush=1, s2_flush=1, muldiv_start=0, stall=0, halted=0.
- RUN priority, highest first:
  1) halt_req: all enables 0, flushes 0, next state HALT.
  2) s3_branch_taken: pc_en=1, pc_sel_branch=1, s1_en=1, s2_en=1, s1_flush=1, s2_flush=1. Stays in RUN; the two younger instructions are killed.
  3) s2_valid & s2_is_muldiv: muldiv_start=1, pc_en=0, s1_en=0, s2_en=1 with s2_flush=1 (bubble to st3; st2 holds), stall=1, cnt<=MULDIV_CYCLES-1, next state MULDIV.
  4) load-use hazard: s2_valid & s2_is_load & s1_valid & s2_rd!=0 & ((s1_uses_rs1 & s1_rs1==s2_rd) | (s1_uses_rs2 & s1_rs2==s2_rd)). Response: pc_en=0, s1_en=1 with s1_flush=1 (bubble into st2), s2_en=1, stall=1. Exactly one stall cycle.
  5) otherwise: pc_en=s1_en=s2_en=1, no flush, stall=0.
- MULDIV: pc_en=0, s1_en=0, s2_en=1 with s2_flush=1, stall=1, cnt decrements each cycle.
  - When cnt==1, next state is RUN. In that first RUN cycle, s2_is_muldiv is ignored for the held instruction (tracked by a registered muldiv_done flag, cleared when s2 advances), so st2 advances normally.
  - Total stall cycles = MULDIV_CYCLES, with muldiv_start asserted exactly once.
  - s3_branch_taken and halt_req are ignored in MULDIV, because st3 holds bubbles.
- HALT: absorbing. All enables 0, flushes 0, halted=1, stall=0. Exits only via rst.
- Register 0 never causes a load-use stall.
- Reset asserted mid-MULDIV aborts the sequence: no further muldiv_start; state is RUN after reset.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: stall_cycles increments on every cycle with stall=1, saturates at 16'hFFFF, and clears on reset.
- Undefined: stall_cycles is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] pipe_state_e {RUN, MULDIV, HALT}
  - localparam REG_ZERO = '0
  - typedef struct pipe_ctl_t bundling pc_en, pc_sel_branch, s1_en, s2_en, s1_flush, s2_flush, used by top to route stage controls.
- One natural sub-module: pipe_hazard_detect, a combinational load-use comparator producing a single hazard bit.

Test Plan:
- Load-use: LOAD r3 in st2, s1 reads r3 via rs2 -> exactly one cycle with pc_en=0, s1_flush=1, stall=1; the next cycle is clean RUN.
- Load into r0 with s1 reading r0 -> no stall; pc_en=1 every cycle.
- MUL in st2 with MULDIV_CYCLES=4 -> muldiv_start pulses once; pc_en=0 for exactly 4 cycles; s2_en without flush on cycle 5.
- s3_branch_taken coincident with a load-use hazard -> branch wins: pc_sel_branch=1, s1_flush=s2_flush=1, stall=0.
- halt_req, then 10 cycles -> halted=1, all enables 0 throughout; rst=0 for one edge returns to RUN with halted=0.
- rst=0 at cycle 2 of MULDIV -> reset output values that cycle; afterwards state RUN, no second muldiv_start until a new mul/div op; with PIPE_PERF_CNT_EN, stall_cycles=0 after reset.
